// File: rtl/puf_uart_pkg.sv
// Shared types and helpers for the PUF response UART sender: FSM state encoding,
// ASCII constants and the nibble-to-ASCII hex encoder.
package puf_uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      START   = 3'd2,
      WAIT_HI = 3'd3,
      WAIT_LO = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [7:0] CR      = 8'h0D;
   localparam logic [7:0] LF      = 8'h0A;
   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_A = 8'h41;

   // Uppercase hex digit for one nibble.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return ASCII_0 + {4'h0, nib};
      else
         return ASCII_A + {4'h0, nib} - 8'd10;
   endfunction

endpackage

// File: rtl/puf_resp_sender_if.sv
// Response-side handshake plus UART-transmitter side signals of the PUF sender.
// The sender uses the slave view; the environment drives the master view.
interface puf_resp_sender_if #(
   parameter int RESP_W = 128
);
   logic [RESP_W-1:0] resp_in;
   logic              resp_valid;
   logic              resp_ready;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              frame_done;

   modport slave (
      input  resp_in, resp_valid, tx_busy,
      output resp_ready, tx_data, tx_start, frame_done
   );

   modport master (
      output resp_in, resp_valid, tx_busy,
      input  resp_ready, tx_data, tx_start, frame_done
   );
endinterface

// File: rtl/puf_resp_sender.sv
// Streams a captured PUF response MSB-first to a UART transmitter, one character per handshake.
// PUF_SENDER_HEX_EN: send each byte as two ASCII hex digits followed by CR LF; otherwise raw bytes.
module puf_resp_sender
   import puf_uart_pkg::*;
#(
   parameter int RESP_W = 128
) (
   input logic              clk,
   input logic              rst,
   puf_resp_sender_if.slave bus
);

   localparam int MAX_CHARS = RESP_W / 4 + 2;
   localparam int IDX_W     = $clog2(MAX_CHARS);
`ifdef PUF_SENDER_HEX_EN
   localparam int N_CHARS   = MAX_CHARS;
   localparam int SHIFT     = 4;
`else
   localparam int N_CHARS   = RESP_W / 8;
   localparam int SHIFT     = 8;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHARS - 1);

   state_t            state, state_next;
   logic [RESP_W-1:0] shreg;
   logic [IDX_W-1:0]  idx;
   logic [7:0]        tx_data_q;
   logic [7:0]        char_cur;
   logic              capture, load, advance;

   // Current character always comes from the top of the shift register.
   always_comb begin
      char_cur = 8'h00;
`ifdef PUF_SENDER_HEX_EN
      if (idx < IDX_W'(RESP_W / 4))
         char_cur = nibble_to_ascii(shreg[RESP_W-1 -: 4]);
      else if (idx == IDX_W'(RESP_W / 4))
         char_cur = CR;
      else
         char_cur = LF;
`else
      char_cur = shreg[RESP_W-1 -: 8];
`endif
   end

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.resp_valid) begin
               capture    = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            load       = 1'b1;
            state_next = START;
         end
         START:   state_next = WAIT_HI;
         WAIT_HI: if (bus.tx_busy) state_next = WAIT_LO;
         WAIT_LO: begin
            if (!bus.tx_busy) begin
               if (idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  advance    = 1'b1;
                  state_next = LOAD;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         idx       <= '0;
         tx_data_q <= 8'h00;
      end else begin
         if (capture) begin
            shreg <= bus.resp_in;
            idx   <= '0;
         end
         if (load)
            tx_data_q <= char_cur;
         if (advance) begin
            shreg <= shreg << SHIFT;
            idx   <= idx + 1'b1;
         end
      end
   end

   assign bus.resp_ready = (state == IDLE);
   assign bus.tx_start   = (state == START);
   assign bus.frame_done = (state == DONE);
   assign bus.tx_data    = tx_data_q;

endmodule
